// File: rtl/uart_pkg.sv
// Shared UART types: parity encodings, TX/RX engine states, bit-counter sizing.
// Imported by uart_core and uart_fifo.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO with occupancy: head visible combinationally, pointers/level update on the push/pop edge.
// Push when full is accepted only alongside a pop; pop when empty only alongside a push (level unchanged).
module uart_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  // Gated so the head reads zero after reset without clearing the array.
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push & (~full | pop);
    pop_ok   = pop & (~empty | push);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/uart_core.sv
// UART controller: FIFO-buffered TX/RX serial engines with parity, stop bits and sticky error flags.
// TXD starts 2 cycles after WE on an idle engine; received words are pushed 1 cycle after the stop sample.
module uart_core import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        rst_n,
  output logic                        UART_TXD,
  input  logic                        UART_RXD,
  input  logic                        WE,
  input  logic [DATA_BITS-1:0]        send_data,
  output logic                        tx_full,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  input  logic                        RE,
  output logic [DATA_BITS-1:0]        receive_data,
  output logic                        rx_empty,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        tx_overflow,
  output logic                        rx_overrun,
  output logic                        rx_parity_err,
  output logic                        rx_frame_err,
  input  logic                        ERR_CLR
);

  localparam int             CW        = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic           PAR_EN    = (PARITY != PAR_NONE);
  localparam logic           PAR_ODD_L = (PARITY == PAR_ODD);

  logic                 tx_pop, tx_empty, tx_load, tx_cnt_end;
  logic [DATA_BITS-1:0] tx_head;
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, txd_q, txd_d, tx_overflow_q, tx_overflow_d;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(CLOCK_50), .rst_n(rst_n), .push(WE), .push_dat(send_data), .pop(tx_pop),
    .head_dat(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    tx_cnt_end = (tx_cnt_q == CNT_LAST);
    tx_load    = 1'b0;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_end ? '0 : tx_cnt_q + CW'(1);
    case (tx_state_q)
      TX_IDLE:  begin
        txd_d   = 1'b1;
        tx_load = ~tx_empty;
      end
      TX_START: if (tx_cnt_end) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
        txd_d      = tx_shift_q[0];
      end
      TX_DATA:  if (tx_cnt_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_idx_q == DATA_LAST) begin
          tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
          txd_d      = PAR_EN ? tx_par_q : 1'b1;
          tx_idx_d   = '0;
        end else begin
          tx_idx_d = tx_idx_q + 3'd1;
          txd_d    = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_cnt_end) begin
        tx_state_d = TX_STOP;
        txd_d      = 1'b1;
        tx_idx_d   = '0;
      end
      TX_STOP:  if (tx_cnt_end) begin
        if (tx_idx_q == STOP_LAST) begin
          tx_state_d = TX_IDLE;
          txd_d      = 1'b1;
          tx_load    = ~tx_empty;
        end else begin
          tx_idx_d = tx_idx_q + 3'd1;
        end
      end
      default:  tx_state_d = TX_IDLE;
    endcase
    // Loading straight out of the last stop bit keeps back-to-back frames gapless.
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ PAR_ODD_L;
      txd_d      = 1'b0;
      tx_cnt_d   = '0;
      tx_state_d = TX_START;
    end
    tx_overflow_d = (tx_overflow_q & ~ERR_CLR) | (WE & tx_full & ~tx_pop);
  end

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d, rx_stop_q, rx_stop_d, rx_fin_q, rx_fin_d;
  logic                 rx_overrun_q, rx_overrun_d, rx_parity_err_q, rx_parity_err_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_sample, rx_par_bad, rx_push, rx_full;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(CLOCK_50), .rst_n(rst_n), .push(rx_push), .push_dat(rx_shift_q), .pop(RE),
    .head_dat(receive_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_stop_d  = rx_stop_q;
    rx_fin_d   = 1'b0;
    // Start bit is sampled at its midpoint; later bits a whole period after that.
    rx_sample  = (rx_state_q == RX_START) ? (rx_cnt_q == CNT_HALF) : (rx_cnt_q == CNT_LAST);
    if (rx_state_q != RX_IDLE) rx_cnt_d = rx_sample ? '0 : rx_cnt_q + CW'(1);
    case (rx_state_q)
      RX_IDLE:   if (rx_prev_q & ~rx_s2_q) rx_state_d = RX_START;
      RX_START:  if (rx_sample) begin
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        rx_idx_d   = '0;
      end
      RX_DATA:   if (rx_sample) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_idx_q == DATA_LAST) rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
        else                       rx_idx_d   = rx_idx_q + 3'd1;
      end
      RX_PARITY: if (rx_sample) begin
        rx_par_d   = rx_s2_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP:   if (rx_sample) begin
        rx_stop_d  = rx_s2_q;
        rx_fin_d   = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default:   rx_state_d = RX_IDLE;
    endcase
    rx_par_bad      = PAR_EN && (((^rx_shift_q) ^ rx_par_q) != PAR_ODD_L);
    rx_push         = rx_fin_q & rx_stop_q & ~rx_par_bad & ~(rx_full & ~RE);
    rx_frame_err_d  = (rx_frame_err_q & ~ERR_CLR) | (rx_fin_q & ~rx_stop_q);
    rx_parity_err_d = (rx_parity_err_q & ~ERR_CLR) | (rx_fin_q & rx_stop_q & rx_par_bad);
    rx_overrun_d    = (rx_overrun_q & ~ERR_CLR)
                    | (rx_fin_q & rx_stop_q & ~rx_par_bad & rx_full & ~RE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      tx_state_q      <= TX_IDLE;
      tx_cnt_q        <= '0;
      tx_idx_q        <= '0;
      tx_shift_q      <= '0;
      tx_par_q        <= 1'b0;
      txd_q           <= 1'b1;
      tx_overflow_q   <= 1'b0;
      rx_s1_q         <= 1'b1;
      rx_s2_q         <= 1'b1;
      rx_prev_q       <= 1'b1;
      rx_state_q      <= RX_IDLE;
      rx_cnt_q        <= '0;
      rx_idx_q        <= '0;
      rx_shift_q      <= '0;
      rx_par_q        <= 1'b0;
      rx_stop_q       <= 1'b1;
      rx_fin_q        <= 1'b0;
      rx_overrun_q    <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
    end else begin
      tx_state_q      <= tx_state_d;
      tx_cnt_q        <= tx_cnt_d;
      tx_idx_q        <= tx_idx_d;
      tx_shift_q      <= tx_shift_d;
      tx_par_q        <= tx_par_d;
      txd_q           <= txd_d;
      tx_overflow_q   <= tx_overflow_d;
      rx_s1_q         <= UART_RXD;
      rx_s2_q         <= rx_s1_q;
      rx_prev_q       <= rx_s2_q;
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_idx_q        <= rx_idx_d;
      rx_shift_q      <= rx_shift_d;
      rx_par_q        <= rx_par_d;
      rx_stop_q       <= rx_stop_d;
      rx_fin_q        <= rx_fin_d;
      rx_overrun_q    <= rx_overrun_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
    end
  end

  assign UART_TXD      = txd_q;
  assign tx_overflow   = tx_overflow_q;
  assign rx_overrun    = rx_overrun_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err  = rx_frame_err_q;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench: an 8N1 instance driven serially, and an even-parity instance with TXD looped to RXD.
`timescale 1ns/1ps
module tb_uart_core;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       txd_n, rxd_n, we_n, re_n, tx_full_n, rx_empty_n, err_clr_n;
  logic [7:0] send_n, rdata_n;
  logic [4:0] tx_level_n, rx_level_n;
  logic       ovf_n, ovr_n, perr_n, ferr_n;
  logic       txd_e, we_e, re_e, tx_full_e, rx_empty_e, err_clr_e;
  logic [7:0] send_e, rdata_e;
  logic [4:0] tx_level_e, rx_level_e;
  logic       ovf_e, ovr_e, perr_e, ferr_e;

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) dut_n (
    .CLOCK_50(clk), .rst_n(rst_n), .UART_TXD(txd_n), .UART_RXD(rxd_n), .WE(we_n),
    .send_data(send_n), .tx_full(tx_full_n), .tx_level(tx_level_n), .RE(re_n),
    .receive_data(rdata_n), .rx_empty(rx_empty_n), .rx_level(rx_level_n),
    .tx_overflow(ovf_n), .rx_overrun(ovr_n), .rx_parity_err(perr_n), .rx_frame_err(ferr_n),
    .ERR_CLR(err_clr_n));

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1)) dut_e (
    .CLOCK_50(clk), .rst_n(rst_n), .UART_TXD(txd_e), .UART_RXD(txd_e), .WE(we_e),
    .send_data(send_e), .tx_full(tx_full_e), .tx_level(tx_level_e), .RE(re_e),
    .receive_data(rdata_e), .rx_empty(rx_empty_e), .rx_level(rx_level_e),
    .tx_overflow(ovf_e), .rx_overrun(ovr_e), .rx_parity_err(perr_e), .rx_frame_err(ferr_e),
    .ERR_CLR(err_clr_e));

  typedef struct { logic [15:0] bits; int n; } frame_t;

  frame_t     exp_tx_n[$], exp_tx_e[$];
  logic [7:0] exp_rx_n[$], exp_rx_e[$];
  int         checks = 0, errors = 0;
  int         frames_n = 0, frames_e = 0;
  bit         drain_n = 0, drain_e = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitted bit i of the frame is bits[i]: start, data LSB first, [parity], stop.
  function automatic frame_t mk_frame(input logic [7:0] d);
    frame_t f;
    f.bits = {6'b0, 1'b1, d, 1'b0};
    f.n    = 10;
    return f;
  endfunction

  function automatic logic txd_of(input int k);
    return (k == 0) ? txd_n : txd_e;
  endfunction

  task automatic mon_tx(input int k);
    frame_t f;
    bit     bad, aborted, none;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || txd_of(k) !== 1'b0) continue;
      if (k == 0) frames_n++; else frames_e++;
      none = (k == 0) ? (exp_tx_n.size() == 0) : (exp_tx_e.size() == 0);
      if (none) begin
        checks++; errors++;
        $display("FAIL tx_unexpected_frame dut%0d: start bit seen, none expected", k);
        repeat (12 * CPB) @(negedge clk);
        continue;
      end
      if (k == 0) f = exp_tx_n.pop_front(); else f = exp_tx_e.pop_front();
      bad = 0; aborted = 0;
      for (int b = 0; b < f.n && !aborted; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (rst_n !== 1'b1) begin aborted = 1; break; end
          if (txd_of(k) !== f.bits[b]) bad = 1;
          if (!(b == f.n - 1 && c == CPB - 1)) @(negedge clk);
        end
      end
      if (!aborted) begin
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL tx_frame dut%0d: serial waveform differs from required bits 0x%0h", k, f.bits);
        end
      end
    end
  endtask

  task automatic mon_rx(input int k);
    logic [7:0] got, exp;
    logic       emp;
    bit         en, none;
    forever begin
      @(negedge clk);
      if (k == 0) begin re_n = 0; en = drain_n; emp = rx_empty_n; got = rdata_n; end
      else        begin re_e = 0; en = drain_e; emp = rx_empty_e; got = rdata_e; end
      if (en && emp === 1'b0) begin
        checks++;
        none = (k == 0) ? (exp_rx_n.size() == 0) : (exp_rx_e.size() == 0);
        if (none) begin
          errors++;
          $display("FAIL rx_unexpected_word dut%0d: got 0x%0h, expected none", k, got);
        end else begin
          if (k == 0) exp = exp_rx_n.pop_front(); else exp = exp_rx_e.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL rx_word dut%0d: got 0x%0h, expected 0x%0h", k, got, exp);
          end
        end
        if (k == 0) re_n = 1; else re_e = 1;
      end
    end
  endtask

  initial mon_tx(0);
  initial mon_tx(1);
  initial mon_rx(0);
  initial mon_rx(1);

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx_n(input logic [7:0] d, input logic stop);
    rxd_n = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_n = d[i];
      tick(CPB);
    end
    rxd_n = stop;
    tick(CPB);
    rxd_n = 1'b1;
  endtask

  task automatic loop_e(input logic [7:0] d, input logic [15:0] bits, input string tag);
    int t;
    exp_tx_e.push_back('{bits, 11});
    exp_rx_e.push_back(d);
    we_e = 1; send_e = d;
    tick();
    we_e = 0;
    t = 0;
    while (rx_empty_e !== 1'b0 && t < 100) begin tick(); t++; end
    chk({tag, "_arrive_in_time"}, (t < 100), 1);
    chk({tag, "_rx_level"}, rx_level_e, 1);
    chk({tag, "_head"}, rdata_e, d);
    chk({tag, "_flags"}, {ovf_e, ovr_e, perr_e, ferr_e}, 0);
    drain_e = 1;
    tick(4);
    drain_e = 0;
    chk({tag, "_drained"}, {rx_empty_e, rx_level_e}, {1'b1, 5'd0});
    chk({tag, "_tx_frame_seen"}, exp_tx_e.size(), 0);
  endtask

  initial begin
    int t, fr;
    rst_n = 0; rxd_n = 1; we_n = 0; we_e = 0; send_n = 0; send_e = 0;
    err_clr_n = 0; err_clr_e = 0;
    tick(3);
    chk("rst_n_outputs", {txd_n, tx_full_n, rx_empty_n, tx_level_n, rx_level_n, rdata_n},
        {1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 8'd0});
    chk("rst_n_flags", {ovf_n, ovr_n, perr_n, ferr_n}, 0);
    chk("rst_e_outputs", {txd_e, tx_full_e, rx_empty_e, tx_level_e, rx_level_e, rdata_e,
        ovf_e, ovr_e, perr_e, ferr_e}, {1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 8'd0, 4'd0});
    rst_n = 1;
    tick(2);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    exp_tx_n.push_back('{16'h034A, 10});
    we_n = 1; send_n = 8'hA5;
    tick();
    we_n = 0;
    chk("tx_cycle1_txd_idle", txd_n, 1'b1);
    chk("tx_level_after_we", tx_level_n, 1);
    tick();
    chk("tx_cycle2_txd_start", txd_n, 1'b0);
    chk("tx_level_after_load", tx_level_n, 0);
    tick(45);
    chk("tx_a5_frame_seen", {frames_n, exp_tx_n.size()}, {32'd1, 32'd0});

    // Even parity loopback: 0x3C has four ones (parity 0), 0x3D five (parity 1)
    loop_e(8'h3C, 16'h0478, "loop_3c");
    loop_e(8'h3D, 16'h067A, "loop_3d");

    // 18 back-to-back writes: one into the shifter, 16 queued, the 18th dropped
    for (int i = 0; i < 18; i++) begin
      we_n = 1; send_n = 8'h10 + 8'(i);
      if (i < 17) exp_tx_n.push_back(mk_frame(8'h10 + 8'(i)));
      tick();
    end
    we_n = 0;
    chk("ovf_tx_level", tx_level_n, 16);
    chk("ovf_tx_full", tx_full_n, 1'b1);
    chk("ovf_flag", ovf_n, 1'b1);
    tick(720);
    chk("ovf_frames_sent", {frames_n, exp_tx_n.size()}, {32'd18, 32'd0});
    chk("ovf_fifo_drained", {tx_full_n, tx_level_n}, 0);
    err_clr_n = 1; tick(); err_clr_n = 0;
    chk("ovf_cleared", ovf_n, 1'b0);

    // Stop bit low: word discarded, frame error; then clear; then 1-cycle glitch
    send_rx_n(8'h55, 1'b0);
    tick(4);
    chk("ferr_set", ferr_n, 1'b1);
    chk("ferr_no_push", {rx_empty_n, rx_level_n}, {1'b1, 5'd0});
    err_clr_n = 1; tick(); err_clr_n = 0;
    chk("ferr_cleared", ferr_n, 1'b0);
    rxd_n = 0; tick(); rxd_n = 1;
    tick(20);
    chk("glitch_no_push", {rx_empty_n, rx_level_n, ovf_n, ovr_n, perr_n, ferr_n}, {1'b1, 9'd0});
    exp_rx_n.push_back(8'h96);
    drain_n = 1;
    send_rx_n(8'h96, 1'b1);
    tick(8);
    drain_n = 0;
    chk("rx_96_consumed", {exp_rx_n.size(), 27'd0, rx_empty_n}, {32'd0, 27'd0, 1'b1});

    // 17 frames with RE idle: 16 stored, the 17th overruns
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_rx_n.push_back(8'h60 + 8'(i));
      send_rx_n(8'h60 + 8'(i), 1'b1);
    end
    tick(6);
    chk("ovr_rx_level", rx_level_n, 16);
    chk("ovr_flag", {ovr_n, perr_n, ferr_n}, 3'b100);
    chk("ovr_head", rdata_n, 8'h60);
    drain_n = 1;
    t = 0;
    while (rx_empty_n !== 1'b1 && t < 60) begin tick(); t++; end
    tick(2);
    drain_n = 0;
    chk("ovr_drain_in_time", (t < 60), 1);
    chk("ovr_all_popped", exp_rx_n.size(), 0);
    err_clr_n = 1; tick(); err_clr_n = 0;

    // Reset in the middle of a data bit with a second word queued
    fr = frames_n;
    exp_tx_n.push_back(mk_frame(8'hC3));
    we_n = 1; send_n = 8'hC3; tick();
    send_n = 8'h5A; tick();
    we_n = 0;
    tick(13);
    rst_n = 0;
    tick();
    chk("rst_mid_txd_high", txd_n, 1'b1);
    chk("rst_mid_tx_level", tx_level_n, 0);
    rst_n = 1;
    tick(100);
    chk("rst_mid_no_more_frames", frames_n, fr + 1);
    chk("rst_mid_txd_idle", txd_n, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
